y86_instr_encoder: RTL and testbench

- Encoder end of the Y86-64 instruction-fetch interface. The fetch stage decodes a byte stream into icode/ifun/rA/rB/valC; this block takes those same fields and serialises them, one byte per cycle, into instruction-memory writes.
- Used as the program loader that fills instruction memory before or between processor runs.
- Produces exactly the byte layout, lengths and little-endian valC ordering that fetch consumes.

---
 rtl/y86_instr_encoder.sv | 214 +++++++++++++++++++++
 tb/tb_y86_instr_encoder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_instr_encoder.sv
// Y86-64 instruction encoder: serialises icode/ifun/rA/rB/valC into the byte
// stream that fetch decodes, one instruction-memory byte write per cycle.
module y86_instr_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'd32,
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_icode,
    input  logic [3:0]  in_ifun,
    input  logic [3:0]  in_rA,
    input  logic [3:0]  in_rB,
    input  logic [63:0] in_valC,
    input  logic        addr_load,
    input  logic [63:0] addr_load_val,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        wr_ready,
    output logic        busy,
    output logic        instr_done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [63:0] next_addr
);

    localparam logic [3:0] IC_IRMOVQ = 4'h3;
    localparam logic [3:0] IC_PUSHQ  = 4'hA;
    localparam logic [3:0] IC_POPQ   = 4'hB;
    localparam int         MAX_LEN   = 10;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_INSTR = 2'd1;
    localparam logic [1:0] ERR_BOUND = 2'd2;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_e;

    state_e      r_state;
    logic        r_ready;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [63:0] r_next_addr;
    logic        r_wr_en;
    logic [63:0] r_wr_addr;
    logic [7:0]  r_wr_data;
    logic [3:0]  r_idx;
    logic [3:0]  r_len;
    logic [7:0]  r_image [MAX_LEN];

    logic [3:0]  w_len;
    logic        w_fields_ok;
    logic        w_has_reg;
    logic        w_has_valc;
    logic        w_valc_after_reg;
    logic [3:0]  w_reg_a;
    logic [3:0]  w_reg_b;
    logic [7:0]  w_image [MAX_LEN];
    logic [63:0] w_base;
    logic [64:0] w_end;
    logic        w_oob;
    logic        w_accept;
    logic        w_last;
    logic [3:0]  w_idx_nxt;

    function automatic logic [3:0] f_len(input logic [3:0] icode);
        case (icode)
            4'h0, 4'h1, 4'h9:       return 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
            4'h7, 4'h8:             return 4'd9;
            4'h3, 4'h4, 4'h5:       return 4'd10;
            default:                return 4'd1;
        endcase
    endfunction

    function automatic logic f_fields_ok(input logic [3:0] icode, input logic [3:0] ifun);
        case (icode)
            4'h2, 4'h7: return ifun <= 4'd6;
            4'h6:       return ifun <= 4'd3;
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                        return ifun == 4'd0;
            default:    return 1'b0;
        endcase
    endfunction

    assign w_len            = f_len(in_icode);
    assign w_fields_ok      = f_fields_ok(in_icode, in_ifun);
    assign w_has_reg        = (in_icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB});
    assign w_valc_after_reg = (in_icode inside {4'h3, 4'h4, 4'h5});
    assign w_has_valc       = w_valc_after_reg || (in_icode inside {4'h7, 4'h8});
    assign w_reg_a          = (in_icode == IC_IRMOVQ) ? 4'hF : in_rA;
    assign w_reg_b          = (in_icode == IC_PUSHQ || in_icode == IC_POPQ) ? 4'hF : in_rB;

    // A same-cycle pointer load takes effect before the instruction is placed.
    assign w_base   = addr_load ? addr_load_val : r_next_addr;
    assign w_end    = {1'b0, w_base} + {61'd0, w_len};
    assign w_oob    = w_end > 65'(MEM_BYTES);
    assign w_accept = in_valid && r_ready && (r_state == S_IDLE);

    assign w_last    = (r_idx == r_len - 4'd1);
    assign w_idx_nxt = r_idx + 4'd1;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            w_image[i] = 8'h00;
        end
        w_image[0] = {in_icode, in_ifun};
        if (w_has_reg) begin
            w_image[1] = {w_reg_a, w_reg_b};
        end
        if (w_has_valc) begin
            for (int i = 0; i < 8; i++) begin
                if (w_valc_after_reg) begin
                    w_image[2 + i] = in_valC[8*i +: 8];
                end else begin
                    w_image[1 + i] = in_valC[8*i +: 8];
                end
            end
        end
    end

    // NOTE: the byte image is plain storage with no reset; it is always
    // rewritten at accept before any of it is read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_image <= w_image;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_next_addr <= BASE_ADDR;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= 64'd0;
            r_wr_data   <= 8'h00;
            r_idx       <= 4'd0;
            r_len       <= 4'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (addr_load) begin
                        r_next_addr <= addr_load_val;
                    end
                    if (w_accept) begin
                        if (!w_fields_ok) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_INSTR;
                        end else if (w_oob) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_BOUND;
                        end else begin
                            r_state    <= S_EMIT;
                            r_ready    <= 1'b0;
                            r_busy     <= 1'b1;
                            r_wr_en    <= 1'b1;
                            r_wr_addr  <= w_base;
                            r_wr_data  <= w_image[0];
                            r_idx      <= 4'd0;
                            r_len      <= w_len;
                            r_err_code <= ERR_NONE;
                        end
                    end
                end
                S_EMIT: begin
                    // Address and data stay put until the memory takes the byte.
                    if (r_wr_en && wr_ready) begin
                        r_next_addr <= r_next_addr + 64'd1;
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_wr_en <= 1'b0;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_wr_addr <= r_next_addr + 64'd1;
                            r_wr_data <= r_image[w_idx_nxt];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = r_ready;
    assign busy       = r_busy;
    assign instr_done = r_done;
    assign err        = r_err;
    assign err_code   = r_err_code;
    assign next_addr  = r_next_addr;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Bench for y86_instr_encoder: directed scenarios plus random instructions,
// checked by a scoreboard fed from a byte-list reference model.
module tb_y86_instr_encoder;

    localparam logic [63:0] BASE = 64'd32;
    localparam int          MEMB = 1024;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_icode;
    logic [3:0]  in_ifun;
    logic [3:0]  in_rA;
    logic [3:0]  in_rB;
    logic [63:0] in_valC;
    logic        addr_load;
    logic [63:0] addr_load_val;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ready;
    logic        busy;
    logic        instr_done;
    logic        err;
    logic [1:0]  err_code;
    logic [63:0] next_addr;

    y86_instr_encoder #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
        .in_valC(in_valC),
        .addr_load(addr_load), .addr_load_val(addr_load_val),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .instr_done(instr_done), .err(err), .err_code(err_code),
        .next_addr(next_addr)
    );

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        int          cyc;
    } ev_t;

    wr_t         wq[$];
    ev_t         evq[$];
    logic [7:0]  m_img[$];
    bit          m_valid;
    logic [63:0] model_ptr = BASE;
    logic [1:0]  exp_err_code = 2'd0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hs       = 0;
    bit in_rst   = 1'b1;
    int rdy_mode = 0;
    int stall_ph = 0;

    bit  mon_emit;
    wr_t mon_wr;
    ev_t mon_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // wr_ready: 0 = always ready, 1 = repeating 1,0,0 pattern, 2 = random
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                wr_ready = (stall_ph == 0);
                stall_ph = (stall_ph + 1) % 3;
            end
            2:       wr_ready = 1'($urandom_range(0, 1));
            default: wr_ready = 1'b1;
        endcase
    end

    // Reference: instruction bytes laid out as fetch reads them.
    function automatic void build_model(input logic [3:0] ic, input logic [3:0] f,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [63:0] vc);
        int max_ifun [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};
        logic [3:0] a;
        logic [3:0] b;
        m_img.delete();
        m_valid = (max_ifun[ic] >= 0) && (int'(f) <= max_ifun[ic]);
        a = (ic == 4'h3) ? 4'hF : ra;
        b = (ic inside {4'hA, 4'hB}) ? 4'hF : rb;
        m_img.push_back({ic, f});
        if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB})
            m_img.push_back({a, b});
        if (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8})
            for (int i = 0; i < 8; i++) m_img.push_back(vc[8*i +: 8]);
    endfunction

    task automatic send(input logic [3:0] ic, input logic [3:0] f,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc, input bit ld, input logic [63:0] ldv,
                        output int acc);
        int  n;
        bit  ok;
        bit  timed;
        logic [64:0] endp;
        in_icode = ic; in_ifun = f; in_rA = ra; in_rB = rb; in_valC = vc;
        addr_load = ld; addr_load_val = ldv;
        in_valid = 1'b1;
        n = 0; ok = 1'b0; acc = -1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0; addr_load = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0; addr_load = 1'b0;
        timed = (rdy_mode == 0);
        if (ld) model_ptr = ldv;
        build_model(ic, f, ra, rb, vc);
        endp = {1'b0, model_ptr} + 65'(m_img.size());
        if (!m_valid) begin
            evq.push_back('{1'b1, 2'd1, acc});
            exp_err_code = 2'd1;
        end else if (endp > 65'(MEMB)) begin
            evq.push_back('{1'b1, 2'd2, acc});
            exp_err_code = 2'd2;
        end else begin
            for (int k = 0; k < m_img.size(); k++)
                wq.push_back('{model_ptr + 64'(k), m_img[k], timed ? acc + k : -1});
            evq.push_back('{1'b0, 2'd0, timed ? acc + m_img.size() : -1});
            model_ptr = model_ptr + 64'(m_img.size());
            exp_err_code = 2'd0;
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((wq.size() != 0 || evq.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_writes_drained"}, 64'(wq.size()), 64'd0);
        check({name, "_events_drained"}, 64'(evq.size()), 64'd0);
        wq.delete();
        evq.delete();
        check({name, "_next_addr"}, next_addr, model_ptr);
    endtask

    task automatic load_addr(input logic [63:0] v);
        addr_load = 1'b1;
        addr_load_val = v;
        @(posedge clk);
        #1;
        addr_load = 1'b0;
        model_ptr = v;
        check("load_next_addr", next_addr, v);
    endtask

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk) begin
        if (!in_rst) begin
            mon_emit = (wq.size() != 0);
            check("wr_en", 64'(wr_en), 64'(mon_emit));
            check("busy", 64'(busy), 64'(mon_emit));
            check("in_ready", 64'(in_ready), 64'(!mon_emit));
            check("err_code", 64'(err_code), 64'(exp_err_code));
            check("done_and_err", 64'(instr_done & err), 64'd0);
            if (wr_en && mon_emit) begin
                check("wr_addr", wr_addr, wq[0].addr);
                check("wr_data", 64'(wr_data), 64'(wq[0].data));
                if (wr_ready) begin
                    mon_wr = wq.pop_front();
                    hs++;
                    if (mon_wr.cyc >= 0) check("wr_cycle", 64'(cyc), 64'(mon_wr.cyc));
                end
            end
            if (instr_done || err) begin
                if (evq.size() == 0) begin
                    check("unexpected_event", 64'({instr_done, err}), 64'd0);
                end else begin
                    mon_ev = evq.pop_front();
                    check("event_err", 64'(err), 64'(mon_ev.is_err));
                    check("event_done", 64'(instr_done), 64'(!mon_ev.is_err));
                    if (mon_ev.cyc >= 0) check("event_cycle", 64'(cyc), 64'(mon_ev.cyc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1);
    end

    initial begin
        int a1;
        int a2;
        logic [3:0]  ic;
        logic [3:0]  f;
        bit          ld;
        logic [63:0] ldv;

        rst_n = 1'b0; in_valid = 1'b0; addr_load = 1'b0; addr_load_val = '0;
        in_icode = '0; in_ifun = '0; in_rA = '0; in_rB = '0; in_valC = '0;
        wr_ready = 1'b1;
        #23;
        check("rst_next_addr", next_addr, BASE);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wr_addr", wr_addr, 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(instr_done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_first_edge", 64'(in_ready), 64'd1);
        in_rst = 1'b0;

        // irmovq at the boot pointer, full-speed memory
        send(4'h3, 4'h0, 4'h0, 4'h0, 64'h0123456789ABCDEF, 1'b0, '0, a1);
        wait_idle("irmovq");
        check("irmovq_end_ptr", next_addr, 64'd42);

        // halt then ret, back to back
        send(4'h0, 4'h0, 4'h0, 4'h0, '0, 1'b0, '0, a1);
        send(4'h9, 4'h0, 4'h0, 4'h0, '0, 1'b0, '0, a2);
        check("b2b_accept_gap", 64'(a2 - a1), 64'd2);
        wait_idle("halt_ret");
        check("halt_ret_end_ptr", next_addr, 64'd44);

        // rmmovq %rcx,8(%rbx) against a stalling memory
        hs = 0; stall_ph = 0; rdy_mode = 1;
        send(4'h4, 4'h0, 4'h1, 4'h3, 64'd8, 1'b0, '0, a1);
        wait_idle("stall_rmmovq");
        check("stall_handshakes", 64'(hs), 64'd10);
        rdy_mode = 0;

        // rejected encodings
        send(4'hC, 4'h0, 4'h0, 4'h0, '0, 1'b0, '0, a1);
        wait_idle("bad_icode");
        send(4'h6, 4'h5, 4'h1, 4'h2, '0, 1'b0, '0, a1);
        wait_idle("bad_opq_ifun");

        // bounds: 1020+9 overflows, 1015+9 lands exactly on the end
        load_addr(64'd1020);
        send(4'h7, 4'h0, 4'h0, 4'h0, 64'h100, 1'b0, '0, a1);
        wait_idle("jmp_oob");
        load_addr(64'd1015);
        send(4'h7, 4'h0, 4'h0, 4'h0, 64'h100, 1'b0, '0, a1);
        wait_idle("jmp_fits");
        check("jmp_fits_end_ptr", next_addr, 64'd1024);

        // pointer load in the same cycle as an instruction
        send(4'h1, 4'h0, 4'h0, 4'h0, '0, 1'b1, 64'd200, a1);
        wait_idle("load_with_nop");

        // reset after the 4th byte of an mrmovq
        load_addr(64'd500);
        hs = 0;
        send(4'h5, 4'h0, 4'h2, 4'h4, 64'hDEADBEEF00112233, 1'b0, '0, a1);
        repeat (4) @(posedge clk);
        #2;
        check("bytes_before_reset", 64'(hs), 64'd4);
        in_rst = 1'b1;
        wq.delete(); evq.delete();
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", 64'(wr_en), 64'd0);
        check("midrst_next_addr", next_addr, BASE);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("midrst_in_ready_held", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        model_ptr = BASE; exp_err_code = 2'd0;
        @(posedge clk);
        #1;
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        in_rst = 1'b0;
        send(4'h1, 4'h0, 4'h0, 4'h0, '0, 1'b0, '0, a1);
        wait_idle("nop_after_reset");

        // random instructions, random memory backpressure
        rdy_mode = 2;
        for (int t = 0; t < 40; t++) begin
            ic  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 11));
            f   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 7));
            ld  = (model_ptr > 64'd900) || ($urandom_range(0, 7) == 0);
            ldv = 64'($urandom_range(0, 1023));
            send(ic, f, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 {$urandom(), $urandom()}, ld, ldv, a1);
        end
        wait_idle("random");
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
